// File: rtl/br_resolve.sv
// EX-stage branch/jump resolution: decides taken, computes the target, and issues a
// registered PC redirect to fetch (valid/ready) while flushing wrong-path stages.
module br_resolve #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_br_unsign,
  output logic             o_redirect_valid,
  output logic [XLEN-1:0]  o_redirect_pc,
  input  logic             i_redirect_ready,
  output logic             o_flush,
  output logic             o_busy,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state, state_nxt;
  logic            cond_taken, taken, accept, count_br, aligned, load_redir;
  logic [XLEN-1:0] sum_jalr, target;

  assign o_br_unsign = i_funct3[1];

  always_comb begin
    cond_taken = 1'b0;
    case (i_funct3)
      3'b000:         cond_taken = i_br_equal;
      3'b001:         cond_taken = ~i_br_equal;
      3'b100, 3'b110: cond_taken = i_br_less;
      3'b101, 3'b111: cond_taken = ~i_br_less;
      default:        cond_taken = 1'b0;
    endcase
  end

  // Jumps win over the branch flag, so any jump flag forces taken.
  assign taken    = i_is_jalr | i_is_jal | (i_is_branch & cond_taken);
  assign sum_jalr = i_rs1_data + i_imm;
  assign target   = i_is_jalr ? {sum_jalr[XLEN-1:1], 1'b0} : (i_pc + i_imm);
  assign aligned  = (target[1:0] == 2'b00);
  assign accept   = i_valid & ~i_stall & (state == IDLE);
  assign count_br = accept & i_is_branch & ~i_is_jal & ~i_is_jalr;

  always_comb begin
    state_nxt        = state;
    load_redir       = 1'b0;
    o_redirect_valid = 1'b0;
    o_flush          = 1'b0;
    o_busy           = 1'b0;
    case (state)
      IDLE: begin
        if (accept & taken & aligned) begin
          state_nxt  = REDIR;
          load_redir = 1'b1;
        end
      end
      REDIR: begin
        o_redirect_valid = 1'b1;
        o_flush          = 1'b1;
        o_busy           = 1'b1;
        if (i_redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_redirect_pc <= '0;
      o_misalign    <= 1'b0;
      o_br_cnt      <= '0;
      o_taken_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      o_misalign <= accept & taken & ~aligned;
      // Target is cleared on handshake so it reads 0 whenever no redirect is pending.
      if (load_redir)
        o_redirect_pc <= target;
      else if (state == REDIR && i_redirect_ready)
        o_redirect_pc <= '0;
      if (count_br && o_br_cnt != CNT_MAX)
        o_br_cnt <= o_br_cnt + 1'b1;
      if (count_br && cond_taken && o_taken_cnt != CNT_MAX)
        o_taken_cnt <= o_taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_br_resolve.sv
// Randomized + directed bench for br_resolve against a cycle-level reference model.
module tb_br_resolve;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk, rst_n;
  logic             valid, stall, is_branch, is_jal, is_jalr;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  pc, imm, rs1;
  logic             less, equal, ready;
  logic             br_unsign, redirect_valid, flush, busy, misalign;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit              m_busy, m_mis;
  logic [XLEN-1:0] m_pc;
  int              m_br, m_tk;

  br_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
    .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
    .i_funct3(funct3), .i_pc(pc), .i_imm(imm), .i_rs1_data(rs1),
    .i_br_less(less), .i_br_equal(equal), .o_br_unsign(br_unsign),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .i_redirect_ready(ready), .o_flush(flush), .o_busy(busy),
    .o_misalign(misalign), .o_br_cnt(br_cnt), .o_taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken();
    if (is_jal || is_jalr) return 1'b1;
    if (!is_branch) return 1'b0;
    case (funct3)
      3'd0:       return equal;
      3'd1:       return !equal;
      3'd4, 3'd6: return less;
      3'd5, 3'd7: return !less;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ref_target();
    if (is_jalr) return (rs1 + imm) & 32'hFFFF_FFFE;
    return pc + imm;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_mis = 0; m_pc = '0; m_br = 0; m_tk = 0;
  endtask

  // One clock edge of the reference behaviour, from the pre-edge inputs.
  task automatic model_edge();
    bit tk, is_cond;
    logic [XLEN-1:0] tgt;
    m_mis = 0;
    if (m_busy) begin
      if (ready) begin m_busy = 0; m_pc = '0; end
    end else if (valid && !stall) begin
      tk      = ref_taken();
      tgt     = ref_target();
      is_cond = is_branch && !is_jal && !is_jalr;
      if (is_cond) begin
        if (m_br < CMAX) m_br++;
        if (tk && m_tk < CMAX) m_tk++;
      end
      if (tk) begin
        if (tgt[1:0] == 2'b00) begin m_busy = 1; m_pc = tgt; end
        else m_mis = 1;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".rvalid"}, redirect_valid, m_busy);
    chk({tag, ".flush"},  flush,          m_busy);
    chk({tag, ".busy"},   busy,           m_busy);
    chk({tag, ".rpc"},    redirect_pc,    m_pc);
    chk({tag, ".mis"},    misalign,       m_mis);
    chk({tag, ".brcnt"},  br_cnt,         m_br);
    chk({tag, ".tkcnt"},  taken_cnt,      m_tk);
  endtask

  task automatic drive(input bit v, st, br, jl, jr, input logic [2:0] f3,
                       input logic [XLEN-1:0] p, im, r1, input bit ls, eq, rdy);
    valid = v; stall = st; is_branch = br; is_jal = jl; is_jalr = jr;
    funct3 = f3; pc = p; imm = im; rs1 = r1; less = ls; equal = eq; ready = rdy;
  endtask

  task automatic idle_in(input bit rdy);
    drive(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, rdy);
  endtask

  // Inputs are set before calling; checks unsign, clocks, steps model, checks outputs.
  task automatic cyc(input string tag);
    #1;
    chk({tag, ".unsign"}, br_unsign, funct3[1]);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in(0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    @(negedge clk) rst_n = 1'b1;

    // BEQ taken, fetch ready
    drive(1, 0, 1, 0, 0, 3'd0, 32'h100, 32'h20, 0, 0, 1, 1);
    cyc("beq");
    chk("beq.pc_const", redirect_pc, 32'h120);
    idle_in(1);
    cyc("beq_hs");
    chk("beq.idle_after", busy, 1'b0);
    chk("beq.cnts", {br_cnt, taken_cnt}, {4'd1, 4'd1});

    // BLTU not taken
    drive(1, 0, 1, 0, 0, 3'd6, 32'h200, 32'h40, 0, 0, 0, 1);
    #1 chk("bltu.unsign_const", br_unsign, 1'b1);
    cyc("bltu");
    chk("bltu.cnts", {br_cnt, taken_cnt}, {4'd2, 4'd1});

    // JALR clears bit0
    drive(1, 0, 0, 0, 1, 3'd0, 32'h300, 32'h3, 32'h2001, 0, 0, 1);
    cyc("jalr");
    chk("jalr.pc_const", redirect_pc, 32'h2004);
    idle_in(1);
    cyc("jalr_hs");

    // JAL misaligned target
    drive(1, 0, 0, 1, 0, 3'd0, 32'h100, 32'h6, 0, 0, 0, 1);
    cyc("jal_mis");
    chk("jal.mis_const", misalign, 1'b1);
    idle_in(1);
    cyc("jal_mis2");

    // BNE taken, fetch stalls 3 cycles, taken branch presented meanwhile
    drive(1, 0, 1, 0, 0, 3'd1, 32'h400, 32'h10, 0, 0, 0, 0);
    cyc("bne");
    repeat (3) begin
      drive(1, 0, 1, 0, 0, 3'd0, 32'h800, 32'h8, 0, 0, 1, 0);
      cyc("bne_hold");
      chk("bne.pc_stable", redirect_pc, 32'h410);
    end
    drive(1, 0, 1, 0, 0, 3'd0, 32'h800, 32'h8, 0, 0, 1, 1);
    cyc("bne_hs");
    // back-to-back: first IDLE cycle accepts
    drive(1, 0, 1, 0, 0, 3'd0, 32'h900, 32'h8, 0, 0, 1, 1);
    cyc("b2b");
    idle_in(1);
    cyc("b2b_hs");

    // saturation
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 1, 0, 0, 3'd5, 32'h1000, 32'h4, 0, 0, 0, 1);
      cyc("sat");
      idle_in(1);
      cyc("sat_hs");
    end
    chk("sat.cnts", {br_cnt, taken_cnt}, {4'd15, 4'd15});

    // stall ignores a taken branch
    drive(1, 1, 1, 0, 0, 3'd0, 32'h100, 32'h20, 0, 0, 1, 1);
    cyc("stall");

    // async reset while redirect pending
    drive(1, 0, 1, 0, 0, 3'd0, 32'h100, 32'h20, 0, 0, 1, 0);
    cyc("pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    @(negedge clk) rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)),
            $urandom & 32'hFFFF_FFFC, 32'($urandom_range(0, 63)) - 32'd16,
            $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 2) != 0);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
